// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// Frame-level scheduler above the convolution controller. It optionally
// requests a coefficient load, then streams HEIGHT x WIDTH samples from the
// upstream FIFO with a row-boundary pulse between rows. It also tracks the
// row/column position, detects a stalled controller and reports completion.
// Outputs are registered copies of the next-state decode, so they never
// depend combinationally on inputs.

module conv_frame_sequencer #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int TIMEOUT = 255,
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          coeff_reload,
  input  logic          abort,
  input  logic          fifo_empty,
  input  logic          modwait,
  output logic          fifo_rd,
  output logic          sample_load_en,
  output logic          coeff_load_en,
  output logic          new_row,
  output logic          busy,
  output logic          frame_done,
  output logic          err,
  output logic [RW-1:0] row_idx,
  output logic [CW-1:0] col_idx
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COEFF_REQ  = 3'd1,
    ST_SAMPLE_ARM = 3'd2,
    ST_SAMPLE_REQ = 3'd3,
    ST_GUARD      = 3'd4,
    ST_WAIT       = 3'd5,
    ST_ROW_END    = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  // Kind of request the controller is currently working on; resolved in WAIT.
  typedef enum logic [1:0] {
    PD_NONE   = 2'd0,
    PD_COEFF  = 2'd1,
    PD_SAMPLE = 2'd2,
    PD_ROW    = 2'd3
  } pend_t;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  pend_t         r_pend;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [TW-1:0] r_tmo;
  logic          r_err;
  logic          r_sample;
  logic          r_coeff;
  logic          r_new_row;
  logic          r_busy;
  logic          r_done;
  logic          w_start_acc;
  logic          w_tmo_hit;
  logic          w_smp_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort overrides every state, including IDLE with start.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_tmo_hit   = 1'b0;
    w_smp_done  = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_start_acc = 1'b1;
            w_state_nxt = coeff_reload ? ST_COEFF_REQ : ST_SAMPLE_ARM;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_COEFF_REQ:  w_state_nxt = ST_GUARD;
        ST_SAMPLE_ARM: begin
          if (!fifo_empty) begin
            w_state_nxt = ST_SAMPLE_REQ;
          end else begin
            w_state_nxt = ST_SAMPLE_ARM;
          end
        end
        ST_SAMPLE_REQ: w_state_nxt = ST_GUARD;
        // modwait is not looked at here: the controller's busy flag lags a cycle.
        ST_GUARD:      w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (!modwait) begin
            if (r_pend == PD_SAMPLE) begin
              w_smp_done = 1'b1;
              if (r_col == COL_LAST) begin
                w_state_nxt = (r_row == ROW_LAST) ? ST_DONE : ST_ROW_END;
              end else begin
                w_state_nxt = ST_SAMPLE_ARM;
              end
            end else begin
              w_state_nxt = ST_SAMPLE_ARM;
            end
          end else if (r_tmo == TMO_LAST) begin
            w_tmo_hit   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_ROW_END:    w_state_nxt = ST_GUARD;
        ST_DONE:       w_state_nxt = ST_IDLE;
        default:       w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Position, timeout and pending-request bookkeeping; abort keeps err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= {RW{1'b0}};
      r_col  <= {CW{1'b0}};
      r_tmo  <= {TW{1'b0}};
      r_err  <= 1'b0;
      r_pend <= PD_NONE;
    end else if (abort) begin
      r_row  <= {RW{1'b0}};
      r_col  <= {CW{1'b0}};
      r_tmo  <= {TW{1'b0}};
      r_pend <= PD_NONE;
    end else begin
      if (w_start_acc) begin
        r_row <= {RW{1'b0}};
        r_col <= {CW{1'b0}};
        r_err <= 1'b0;
      end else if (w_tmo_hit) begin
        r_err <= 1'b1;
      end
      if (w_smp_done) begin
        r_col <= (r_col == COL_LAST) ? {CW{1'b0}} : r_col + CW'(1);
      end
      if (r_state == ST_ROW_END) begin
        r_row <= r_row + RW'(1);
      end
      // GUARD is the only way into WAIT, so clearing there means "on entry".
      if (r_state == ST_GUARD) begin
        r_tmo <= {TW{1'b0}};
      end else if (r_state == ST_WAIT) begin
        r_tmo <= r_tmo + TW'(1);
      end
      case (r_state)
        ST_COEFF_REQ:  r_pend <= PD_COEFF;
        ST_SAMPLE_REQ: r_pend <= PD_SAMPLE;
        ST_ROW_END:    r_pend <= PD_ROW;
        default:       r_pend <= r_pend;
      endcase
    end
  end

  // Registered Moore outputs decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample  <= 1'b0;
      r_coeff   <= 1'b0;
      r_new_row <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sample  <= (w_state_nxt == ST_SAMPLE_REQ);
      r_coeff   <= (w_state_nxt == ST_COEFF_REQ);
      r_new_row <= (w_state_nxt == ST_ROW_END);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign fifo_rd        = r_sample;
  assign sample_load_en = r_sample;
  assign coeff_load_en  = r_coeff;
  assign new_row        = r_new_row;
  assign busy           = r_busy;
  assign frame_done     = r_done;
  assign err            = r_err;
  assign row_idx        = r_row;
  assign col_idx        = r_col;

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level scheduler that sits above the convolution controller and drives its request inputs. On start it optionally triggers a three-coefficient load. It then streams a HEIGHT x WIDTH image, one sample per handshake, from the upstream sample FIFO, and pulses `new_row` between rows. It tracks row/column position, detects a stalled controller by timeout, and reports frame completion.

## Interface
- `WIDTH`, default 8: samples per row, must be ≥ 3.
- `HEIGHT`, default 8: rows per frame, must be ≥ 1.
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before an error is raised, must be ≥ 1.
- `clk`  in  1  system clock, all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `coeff_reload`  in  1  sampled with `start`; 1 means load coefficients before streaming.
- `abort`  in  1  synchronous abort; highest priority after reset.
- `fifo_empty`  in  1  upstream sample FIFO is empty.
- `modwait`  in  1  controller busy flag.
- `fifo_rd`  out  1  pop one sample; asserted together with `sample_load_en`.
- `sample_load_en`  out  1  one-cycle sample request.
- `coeff_load_en`  out  1  one-cycle coefficient-load request.
- `new_row`  out  1  one-cycle row-boundary pulse.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when the frame completes.
- `err`  out  1  sticky timeout flag.
- `row_idx`  out  $clog2(HEIGHT)  current row.
- `col_idx`  out  $clog2(WIDTH)  index of the next sample to issue.

## Operation
- Moore FSM. States: IDLE, COEFF_REQ, SAMPLE_ARM, SAMPLE_REQ, GUARD, WAIT, ROW_END, DONE.
- IDLE transitions:
  - `start`=1 and `coeff_reload`=1 → COEFF_REQ.
  - `start`=1 and `coeff_reload`=0 → SAMPLE_ARM.
  - On any `start`, clear row, column and `err`.
- COEFF_REQ: assert `coeff_load_en`, then → GUARD. The state remembers that the pending request is a coefficient request.
- SAMPLE_ARM: if `fifo_empty`=0 → SAMPLE_REQ; otherwise stay.
- SAMPLE_REQ: assert `sample_load_en` and `fifo_rd`, then → GUARD.
- GUARD: one cycle in which `modwait` is ignored, covering the controller's registered response. Always → WAIT.
- WAIT: hold until `modwait`=0, then resolve the pending request:
  - Coefficient request → SAMPLE_ARM.
  - Sample request → increment `col_idx`.
    - If `col_idx` was WIDTH-1: clear `col_idx`. If `row_idx` = HEIGHT-1 → DONE; otherwise → ROW_END.
    - Otherwise → SAMPLE_ARM.
- ROW_END: assert `new_row` with no other request. Increment `row_idx`, set pending request to "row", then → GUARD. When WAIT resolves a row request → SAMPLE_ARM.
- DONE: assert `frame_done`, then → IDLE.
- Timeout:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT with `modwait` still 1: set `err`, → IDLE, no pulse.
  - `err` holds until the next accepted `start` or `rst`.
- `abort`=1 in any state → IDLE at the next edge. Counters clear; `err` is unchanged; no `frame_done`.
- `start` is ignored while `busy`=1.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- All outputs decode from registered state and counters; none depends combinationally on inputs.
- At most one of `sample_load_en`, `coeff_load_en`, `new_row` is high in any cycle.
- Minimum per-sample spacing is 3 cycles (SAMPLE_REQ, GUARD, WAIT with `modwait`=0) plus one SAMPLE_ARM cycle, so 4 cycles per sample.
- Latency from an accepted `start` to the first `sample_load_en`:
  - With `coeff_reload`=0: 2 cycles.
  - With `coeff_reload`=1: 2 + 3 + (cycles `modwait` stays high).
- FIFO empty during SAMPLE_ARM stalls with no request issued. The FIFO is never read while `fifo_empty`=1.
- `rst` asserted mid-frame: outputs go to 0 immediately (asynchronous) and no pulse completes.
- `abort` and `start` in the same IDLE cycle: `abort` wins and the sequencer stays IDLE.
- A `modwait` rise occurring only after GUARD is honoured; WAIT still waits for it to fall.

## Test plan
- Reset mid-SAMPLE_REQ → all outputs 0 in the same cycle, `row_idx`=`col_idx`=0.
- WIDTH=4, HEIGHT=2, `coeff_reload`=1, FIFO always non-empty, `modwait` high for 3 cycles after each request → exactly:
  - 1 `coeff_load_en`;
  - 8 `sample_load_en`/`fifo_rd` pairs;
  - 1 `new_row`, after the 4th sample;
  - 1 `frame_done`, after the 8th sample;
  - `busy` high throughout, then low.
- Hold `fifo_empty`=1 for 10 cycles before the 3rd sample → no `fifo_rd` during the stall, and `col_idx` stays 2.
- TIMEOUT=5, `modwait` held at 1 → `err`=1 after 5 WAIT cycles, return to IDLE, no `frame_done`. The next `start` clears `err`.
- Assert `abort` during WAIT on the 3rd row → IDLE next cycle, counters 0, no further requests.
- Pulse `start` while `busy`=1 → ignored; the sample count and `frame_done` timing are unchanged.
